// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - pipeline data-memory request bus for the SRAM bridge

interface sram_controller_if;
    // Request side, held stable by the pipeline while ready is low
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;

    // Response side
    logic [31:0] read_data;
    logic        ready;

    // Pipeline memory stage
    modport master (
        output mem_read,
        output mem_write,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    // SRAM controller
    modport slave (
        input  mem_read,
        input  mem_write,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit word access bridge onto a 256Kx16 asynchronous SRAM

module sram_controller #(
    // Extra cycles per halfword access; legal range 1..15 (4-bit phase counter)
    parameter int unsigned SRAM_WAIT = 1,
    // Byte address of data-memory word 0
    parameter logic [31:0] ADDR_BASE = 32'd1024
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    bus,
    output logic [17:0]         sram_addr,
    inout  wire  [15:0]         sram_dq,
    output logic                sram_we_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter value of the final cycle of a halfword phase
    localparam logic [3:0] WAIT_LAST = 4'(SRAM_WAIT);

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          is_write_q;
    logic [16:0]   widx_q;
    logic [15:0]   wdata_hi_q;
    logic [31:0]   read_data_q;
    logic [17:0]   sram_addr_q;
    logic          we_n_q;
    logic          dq_oe_q;
    logic [15:0]   dq_out_q;

    logic [16:0]   widx_d;
    logic          req_d;
    logic          phase_last_d;
    logic [3:0]    cnt_inc_d;

    // Word index relative to the data-memory base; wraps modulo 2^17
    assign widx_d       = 17'((bus.address - ADDR_BASE) >> 2);
    assign req_d        = bus.mem_read | bus.mem_write;
    assign phase_last_d = (cnt_q == WAIT_LAST);
    assign cnt_inc_d    = cnt_q + 4'd1;

    // ready is combinational so the pipeline sees the stall in the request cycle
    assign bus.ready = rst
                     | ((state_q == S_IDLE) & ~req_d)
                     | (state_q == S_DONE);

    assign bus.read_data = read_data_q;
    assign sram_addr     = sram_addr_q;
    assign sram_we_n     = we_n_q;
    assign sram_dq       = dq_oe_q ? dq_out_q : 16'bz;

    // Access sequencer: all SRAM pin values are registered for the cycle being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            is_write_q  <= 1'b0;
            widx_q      <= 17'd0;
            wdata_hi_q  <= 16'd0;
            read_data_q <= 32'd0;
            sram_addr_q <= 18'd0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_d) begin
                        // Write wins when both requests are raised
                        is_write_q  <= bus.mem_write;
                        widx_q      <= widx_d;
                        wdata_hi_q  <= bus.write_data[31:16];
                        cnt_q       <= 4'd0;
                        sram_addr_q <= {widx_d, 1'b0};
                        dq_out_q    <= bus.write_data[15:0];
                        dq_oe_q     <= bus.mem_write;
                        // The first cycle of a phase is never its last, as SRAM_WAIT >= 1
                        we_n_q      <= ~bus.mem_write;
                        state_q     <= S_LOW;
                    end
                end

                S_LOW: begin
                    if (phase_last_d) begin
                        if (!is_write_q) begin
                            read_data_q[15:0] <= sram_dq;
                        end
                        cnt_q       <= 4'd0;
                        sram_addr_q <= {widx_q, 1'b1};
                        dq_out_q    <= wdata_hi_q;
                        we_n_q      <= ~is_write_q;
                        state_q     <= S_HIGH;
                    end else begin
                        cnt_q  <= cnt_inc_d;
                        // Last cycle of the phase releases we_n for address/data hold
                        we_n_q <= ~is_write_q | (cnt_inc_d == WAIT_LAST);
                    end
                end

                S_HIGH: begin
                    if (phase_last_d) begin
                        if (!is_write_q) begin
                            read_data_q[31:16] <= sram_dq;
                        end
                        cnt_q   <= 4'd0;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q  <= cnt_inc_d;
                        we_n_q <= ~is_write_q | (cnt_inc_d == WAIT_LAST);
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed self-checking bench for sram_controller

module tb_sram_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sram_controller_if bus1 ();
    sram_controller_if bus3 ();

    logic [17:0] addr1, addr3;
    logic        we1_n, we3_n;
    wire  [15:0] dq1, dq3;

    // SRAM models: drive enable, override enable and override value per device
    logic        drv1, ovr1, drv3, ovr3;
    logic [15:0] ovr_val1, ovr_val3;
    logic [15:0] mem1 [0:262143];
    logic [15:0] mem3 [0:262143];

    assign dq1 = drv1 ? (ovr1 ? ovr_val1 : mem1[addr1]) : 16'bz;
    assign dq3 = drv3 ? (ovr3 ? ovr_val3 : mem3[addr3]) : 16'bz;

    always @(posedge clk) begin
        if (!we1_n) mem1[addr1] <= dq1;
        if (!we3_n) mem3[addr3] <= dq3;
    end

    sram_controller #(.SRAM_WAIT(1), .ADDR_BASE(32'd1024)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .sram_addr (addr1),
        .sram_dq   (dq1),
        .sram_we_n (we1_n)
    );

    sram_controller #(.SRAM_WAIT(3), .ADDR_BASE(32'd1024)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus3),
        .sram_addr (addr3),
        .sram_dq   (dq3),
        .sram_we_n (we3_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus1.ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready got %b want 1", bus1.ready);
            end
        end
        rst  = 1'b0;
        drv1 = 1'b1;
        ovr1 = 1'b1;
        ovr_val1 = 16'h5A5A;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus1.ready !== 1'b1 || we1_n !== 1'b1 || bus1.read_data !== 32'd0 || addr1 !== 18'd0) begin
                errors++;
                $display("FAIL idle_state c=%0d ready=%b we_n=%b read_data=%h addr=%h want 1 1 0 0",
                         c, bus1.ready, we1_n, bus1.read_data, addr1);
            end
            checks++;
            if (dq1 !== 16'h5A5A) begin
                errors++;
                $display("FAIL idle_dq_highz got %h want 5a5a", dq1);
            end
        end
        checks++;
        if (bus3.ready !== 1'b1 || we3_n !== 1'b1 || bus3.read_data !== 32'd0) begin
            errors++;
            $display("FAIL idle_dut3 ready=%b we_n=%b read_data=%h want 1 1 0", bus3.ready, we3_n, bus3.read_data);
        end
        drv1 = 1'b0;
        ovr1 = 1'b0;
    endtask

    task automatic test_write();
        tick();
        bus1.mem_write  = 1'b1;
        bus1.address    = 32'd1024;
        bus1.write_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus1.ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_c0_ready got %b want 0", bus1.ready);
        end
        tick();
        checks++;
        if (addr1 !== 18'd0 || dq1 !== 16'hBEEF || we1_n !== 1'b0 || bus1.ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_c1 addr=%h dq=%h we_n=%b ready=%b want 0 beef 0 0", addr1, dq1, we1_n, bus1.ready);
        end
        tick();
        checks++;
        if (we1_n !== 1'b1 || dq1 !== 16'hBEEF || addr1 !== 18'd0) begin
            errors++;
            $display("FAIL wr_c2 we_n=%b dq=%h addr=%h want 1 beef 0", we1_n, dq1, addr1);
        end
        tick();
        checks++;
        if (addr1 !== 18'd1 || dq1 !== 16'hDEAD || we1_n !== 1'b0) begin
            errors++;
            $display("FAIL wr_c3 addr=%h dq=%h we_n=%b want 1 dead 0", addr1, dq1, we1_n);
        end
        tick();
        checks++;
        if (we1_n !== 1'b1 || bus1.ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_c4 we_n=%b ready=%b want 1 0", we1_n, bus1.ready);
        end
        tick();
        checks++;
        if (bus1.ready !== 1'b1 || we1_n !== 1'b1) begin
            errors++;
            $display("FAIL wr_c5 ready=%b we_n=%b want 1 1", bus1.ready, we1_n);
        end
        bus1.mem_write = 1'b0;
        tick();
        checks++;
        if (mem1[0] !== 16'hBEEF || mem1[1] !== 16'hDEAD) begin
            errors++;
            $display("FAIL wr_sram got %h %h want beef dead", mem1[0], mem1[1]);
        end
    endtask

    task automatic test_read_back();
        tick();
        bus1.mem_read = 1'b1;
        bus1.address  = 32'd1024;
        drv1 = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            // A late address change must not affect the access in flight
            if (c == 2) bus1.address = 32'd1028;
            checks++;
            if (bus1.ready !== 1'b0) begin
                errors++;
                $display("FAIL rd_stall c=%0d ready got %b want 0", c, bus1.ready);
            end
        end
        tick();
        checks++;
        if (bus1.ready !== 1'b1 || bus1.read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_done ready=%b data=%h want 1 deadbeef", bus1.ready, bus1.read_data);
        end
        bus1.mem_read = 1'b0;
        drv1 = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] addrs [2];
        logic [31:0] datas [2];
        logic [17:0] lo_ha [2];
        addrs[0] = 32'd1028; datas[0] = 32'h12345678; lo_ha[0] = 18'h00002;
        addrs[1] = 32'd1020; datas[1] = 32'hA5A55A5A; lo_ha[1] = 18'h3FFFE;
        for (int t = 0; t < 2; t++) begin
            tick();
            bus1.mem_write  = 1'b1;
            bus1.address    = addrs[t];
            bus1.write_data = datas[t];
            tick();
            checks++;
            if (addr1 !== lo_ha[t] || dq1 !== datas[t][15:0]) begin
                errors++;
                $display("FAIL wrap_low t=%0d addr=%h dq=%h want %h %h", t, addr1, dq1, lo_ha[t], datas[t][15:0]);
            end
            tick();
            tick();
            checks++;
            if (addr1 !== (lo_ha[t] | 18'd1) || dq1 !== datas[t][31:16]) begin
                errors++;
                $display("FAIL wrap_high t=%0d addr=%h dq=%h want %h %h", t, addr1, dq1, lo_ha[t] | 18'd1, datas[t][31:16]);
            end
            tick();
            tick();
            bus1.mem_write = 1'b0;
            tick();
            checks++;
            if (mem1[lo_ha[t]] !== datas[t][15:0] || mem1[lo_ha[t] | 18'd1] !== datas[t][31:16]) begin
                errors++;
                $display("FAIL wrap_sram t=%0d got %h %h want %h", t, mem1[lo_ha[t] | 18'd1], mem1[lo_ha[t]], datas[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ready;
        tick();
        bus1.mem_read = 1'b1;
        bus1.address  = 32'd1028;
        drv1 = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            exp_ready = (c == 5) || (c == 11);
            checks++;
            if (bus1.ready !== exp_ready) begin
                errors++;
                $display("FAIL b2b_ready c=%0d got %b want %b", c, bus1.ready, exp_ready);
            end
            if (c == 5) begin
                checks++;
                if (bus1.read_data !== 32'h12345678) begin
                    errors++;
                    $display("FAIL b2b_data0 got %h want 12345678", bus1.read_data);
                end
                bus1.address = 32'd1020;
            end
            if (c == 11) begin
                checks++;
                if (bus1.read_data !== 32'hA5A55A5A) begin
                    errors++;
                    $display("FAIL b2b_data1 got %h want a5a55a5a", bus1.read_data);
                end
            end
            if (c < 11) tick();
        end
        bus1.mem_read = 1'b0;
        drv1 = 1'b0;
    endtask

    task automatic test_wait_states();
        logic exp_we_n;
        tick();
        bus3.mem_write  = 1'b1;
        bus3.address    = 32'd1024;
        bus3.write_data = 32'hCAFEF00D;
        for (int c = 1; c <= 9; c++) begin
            tick();
            exp_we_n = (c == 4) || (c >= 8);
            checks++;
            if (we3_n !== exp_we_n || bus3.ready !== (c == 9)) begin
                errors++;
                $display("FAIL w3_write c=%0d we_n=%b ready=%b want %b %b", c, we3_n, bus3.ready, exp_we_n, (c == 9));
            end
        end
        bus3.mem_write = 1'b0;
        tick();
        bus3.mem_read = 1'b1;
        drv3 = 1'b1;
        ovr3 = 1'b1;
        ovr_val3 = 16'h0BAD;
        #1;
        checks++;
        if (bus3.ready !== 1'b0) begin
            errors++;
            $display("FAIL w3_rd_c0 ready got %b want 0", bus3.ready);
        end
        for (int c = 1; c <= 9; c++) begin
            tick();
            // Only the last cycle of each phase presents real SRAM data
            ovr3 = !((c == 4) || (c == 8));
            checks++;
            if (bus3.ready !== (c == 9)) begin
                errors++;
                $display("FAIL w3_rd_ready c=%0d got %b want %b", c, bus3.ready, (c == 9));
            end
        end
        checks++;
        if (bus3.read_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL w3_rd_data got %h want cafef00d", bus3.read_data);
        end
        bus3.mem_read = 1'b0;
        drv3 = 1'b0;
        ovr3 = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] prev_hi;
        prev_hi = mem1[9];
        tick();
        bus1.mem_write  = 1'b1;
        bus1.address    = 32'd1040;
        bus1.write_data = 32'h77778888;
        tick();
        checks++;
        if (we1_n !== 1'b0 || addr1 !== 18'd8) begin
            errors++;
            $display("FAIL rstmid_c1 we_n=%b addr=%h want 0 8", we1_n, addr1);
        end
        tick();
        rst = 1'b1;
        bus1.mem_write = 1'b0;
        #1;
        checks++;
        if (bus1.ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready_in_rst got %b want 1", bus1.ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (we1_n !== 1'b1 || bus1.ready !== 1'b1 || bus1.read_data !== 32'd0 || addr1 !== 18'd0) begin
            errors++;
            $display("FAIL rstmid_after we_n=%b ready=%b data=%h addr=%h want 1 1 0 0",
                     we1_n, bus1.ready, bus1.read_data, addr1);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (we1_n !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_quiet c=%0d we_n got %b want 1", c, we1_n);
            end
        end
        checks++;
        if (mem1[9] !== prev_hi || mem1[8] !== 16'h8888) begin
            errors++;
            $display("FAIL rstmid_sram hi=%h lo=%h want %h 8888", mem1[9], mem1[8], prev_hi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drv1 = 1'b0; ovr1 = 1'b0; ovr_val1 = 16'h0;
        drv3 = 1'b0; ovr3 = 1'b0; ovr_val3 = 16'h0;
        bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.address = 32'd0; bus1.write_data = 32'd0;
        bus3.mem_read = 1'b0; bus3.mem_write = 1'b0; bus3.address = 32'd0; bus3.write_data = 32'd0;

        test_reset();
        test_write();
        test_read_back();
        test_wrap();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_access();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage bridge between the pipeline's data-memory requests (`mem_read`/`mem_write` as produced by decode and carried down the pipeline) and an external 256K×16 asynchronous SRAM. Each 32-bit word access is split into two 16-bit SRAM accesses with programmable wait states. While an access is in flight, `ready` stays low so the pipeline freezes. It returns to high for exactly one completion cycle.

## Interface
- `SRAM_WAIT`, 1: extra cycles per halfword access; legal range 1..15.
- `ADDR_BASE`, 1024: byte address of data-memory word 0.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  word read request; held until `ready`.
- `mem_write`  in  1  word write request; held until `ready`.
- `address`  in  32  byte address; bits [1:0] ignored.
- `write_data`  in  32  write word.
- `read_data`  out  32  last completed read word.
- `ready`  out  1  high means no access pending or access completing this cycle.
- `sram_addr`  out  18  SRAM halfword address.
- `sram_dq`  inout  16  SRAM data bus.
- `sram_we_n`  out  1  SRAM write enable, active low.

## Operation
- Word index: `widx` = ((`address` − `ADDR_BASE`) >> 2) mod 2^17. Out-of-range addresses wrap and no error is raised.
- Low half is at `sram_addr` = {`widx`, 0} and carries data [15:0]. High half is at {`widx`, 1} and carries data [31:16].
- FSM states are IDLE, LOW, HIGH and DONE.
  - IDLE: if `mem_write` or `mem_read` is high, capture `address`, `write_data` and the operation into registers, then go to LOW. `mem_write` wins if both are high. If neither is high, stay in IDLE.
  - LOW: lasts `SRAM_WAIT`+1 cycles, counted by a 4-bit counter, then go to HIGH.
  - HIGH: same as LOW, then go to DONE.
  - DONE: unconditionally return to IDLE.
- `ready` is combinational:
  - high in IDLE with no request;
  - high in DONE;
  - high while `rst`=1;
  - low otherwise.
- Write cycles:
  - `sram_dq` is driven with the selected half during all cycles of LOW and HIGH.
  - `sram_we_n` is 0 in every cycle of a phase except its last cycle, which gives address and data hold with `we_n` high.
- Read cycles:
  - `sram_dq` is high-Z and `sram_we_n` is 1.
  - The SRAM data is sampled at the end of the last cycle of each phase, into `read_data`[15:0] during LOW and into `read_data`[31:16] during HIGH.
- `read_data` updates only while a read is in LOW/HIGH. It holds its value through writes and idle cycles.
- Outside LOW/HIGH, `sram_we_n` is 1, `sram_dq` is high-Z, and `sram_addr` holds its last value.

## Timing
- Reset values: state IDLE, counter 0, `read_data` 0, `sram_addr` 0, `sram_we_n` 1, `sram_dq` high-Z, `ready` 1.
- Reset asserted during any state aborts the access at the next edge. `sram_we_n` returns to 1 and the SRAM may hold a partial (low-half-only) write, which is acceptable.
- Latency is counted with the request first seen in cycle 0 (IDLE):
  - LOW occupies cycles 1..W+1.
  - HIGH occupies cycles W+2..2W+2.
  - DONE is cycle 2W+3, where `ready`=1.
  - For W=1 this means 5 stall cycles, with `ready` high in cycle 5.
- Pipeline contract: the requester holds `mem_read`/`mem_write`, `address` and `write_data` stable while `ready`=0. The values captured in IDLE are the ones used, so later changes have no effect.
- Back-to-back: a request arriving in the cycle after DONE is accepted in IDLE, so each access costs 2W+4 cycles with no extra bubble.
- `read_data` is valid and final in the DONE cycle, when `ready`=1.

## Test plan
- Idle: no request for 10 cycles after reset -> `ready`=1, `sram_we_n`=1, `sram_dq` high-Z, `read_data`=0.
- Write, W=1: `mem_write`, `address`=1024, `write_data`=0xDEADBEEF ->
  - cycle 1: `sram_addr`=0, dq=0xBEEF, `we_n`=0;
  - cycle 2: `we_n`=1;
  - cycle 3: `sram_addr`=1, dq=0xDEAD, `we_n`=0;
  - cycle 5: `ready`=1;
  - SRAM model then holds [0]=0xBEEF and [1]=0xDEAD.
- Read-back: `mem_read`, `address`=1024 -> `ready` low for cycles 0–4; in cycle 5 `ready`=1 and `read_data`=0xDEADBEEF.
- Addressing and wrap: write 0x12345678 to `address`=1028 -> halfwords 2 and 3 written. Write to `address`=1020 -> `widx`=0x1FFFF, so `sram_addr`=0x3FFFE then 0x3FFFF.
- Wait states: with `SRAM_WAIT`=3, a read shows `ready` low for cycles 0–8 and `ready`=1 in cycle 9. Data is sampled only at the end of cycles 4 and 8; an SRAM model changing dq in earlier cycles does not affect `read_data`.
- Reset mid-access: assert `rst` in cycle 2 of a write -> next edge gives state IDLE, `sram_we_n`=1, `ready`=1 and `read_data`=0. No high-half write occurs.
